// File: rtl/rep_window_checker_pkg.sv
// Shared types and constants for the repetition-window checker.
package rep_window_checker_pkg;

  typedef enum logic [1:0] {
    FC_ABORT   = 2'b00,
    FC_GUARD   = 2'b01,
    FC_TIMEOUT = 2'b10,
    FC_EXTRA   = 2'b11
  } fail_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/repchk_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module repchk_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/rep_window_checker.sv
// Runtime checker: $rose(trig) |-> guard throughout ev[->REP] / ev[=REP] within WIN cycles.
// Optional macro REPCHK_RETRIGGER_EN: a new rose while armed aborts (code 00) and restarts.
module rep_window_checker
  import rep_window_checker_pkg::*;
#(
  parameter int REP  = 3,
  parameter int WIN  = 32,
  parameter int MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              trig_i,
  input  logic              guard_i,
  input  logic              ev_i,
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [1:0]        fail_code_o,
  output logic [STAT_W-1:0] pass_cnt_o,
  output logic [STAT_W-1:0] fail_cnt_o
);

  localparam int CNT_W = $clog2(REP + 2);
  localparam int EL_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REP);
  localparam logic [EL_W-1:0]  LAST_C = EL_W'(WIN - 1);

`ifdef REPCHK_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  generate
    if (REP < 1 || REP > 255 || WIN < REP || WIN > 65535 || (MODE != 0 && MODE != 1)) begin : g_bad_params
      $fatal(1, "rep_window_checker: illegal REP/WIN/MODE");
    end
  endgenerate

  logic             trig_q;
  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_base, cnt_sum;
  logic [EL_W-1:0]  el_reg, el_next, el_cur;
  logic             busy_reg, busy_next;
  logic             pass_reg, pass_next, fail_reg, fail_next;
  fail_code_e       code_reg, code_next;
  logic             pend_pass_reg, pend_pass_next, pend_fail_reg, pend_fail_next;
  fail_code_e       pend_code_reg, pend_code_next;

  logic       rose, active, start, abort, last, dec_pass, dec_fail;
  fail_code_e dec_code;

  assign rose = trig_i & ~trig_q;

  always_comb begin
    active = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    if (en_i) begin
      if (state_reg == ST_IDLE) begin
        active = rose;
        start  = rose;
      end else begin
        active = 1'b1;
        abort  = RETRIG & rose;
        start  = abort;
      end
    end

    // A restart evaluates the current cycle as cycle 0 of the fresh attempt.
    cnt_base = start ? '0 : cnt_reg;
    el_cur   = start ? '0 : el_reg;
    cnt_sum  = cnt_base + CNT_W'(ev_i);
    last     = (el_cur == LAST_C);

    dec_pass = 1'b0;
    dec_fail = 1'b0;
    dec_code = FC_ABORT;
    if (active) begin
      if (!guard_i) begin
        dec_fail = 1'b1;
        dec_code = FC_GUARD;
      end else if (MODE == 0 && cnt_sum == REP_C) begin
        dec_pass = 1'b1;
      end else if (MODE == 1 && cnt_sum > REP_C) begin
        dec_fail = 1'b1;
        dec_code = FC_EXTRA;
      end else if (MODE == 1 && last && cnt_sum == REP_C) begin
        dec_pass = 1'b1;
      end else if (last) begin
        dec_fail = 1'b1;
        dec_code = FC_TIMEOUT;
      end
    end

    state_next = state_reg;
    cnt_next   = cnt_reg;
    el_next    = el_reg;
    if (state_reg == ST_ARMED && !en_i) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      el_next    = '0;
    end else if (active) begin
      if (dec_pass || dec_fail) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        el_next    = '0;
      end else begin
        state_next = ST_ARMED;
        cnt_next   = cnt_sum;
        el_next    = el_cur + 1'b1;
      end
    end

    busy_next = (state_next == ST_ARMED) ||
                (state_reg == ST_ARMED && en_i && (dec_pass || dec_fail || abort));

    pass_next      = 1'b0;
    fail_next      = 1'b0;
    code_next      = FC_ABORT;
    pend_pass_next = 1'b0;
    pend_fail_next = 1'b0;
    pend_code_next = FC_ABORT;
    // The abort pulse goes first; a same-cycle verdict of the new attempt waits one cycle.
    if (pend_pass_reg || pend_fail_reg) begin
      pass_next = pend_pass_reg;
      fail_next = pend_fail_reg;
      code_next = pend_code_reg;
    end else if (abort) begin
      fail_next      = 1'b1;
      code_next      = FC_ABORT;
      pend_pass_next = dec_pass;
      pend_fail_next = dec_fail;
      pend_code_next = dec_fail ? dec_code : FC_ABORT;
    end else begin
      pass_next = dec_pass;
      fail_next = dec_fail;
      code_next = dec_fail ? dec_code : FC_ABORT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q        <= 1'b0;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      el_reg        <= '0;
      busy_reg      <= 1'b0;
      pass_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      code_reg      <= FC_ABORT;
      pend_pass_reg <= 1'b0;
      pend_fail_reg <= 1'b0;
      pend_code_reg <= FC_ABORT;
    end else begin
      trig_q        <= trig_i;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      el_reg        <= el_next;
      busy_reg      <= busy_next;
      pass_reg      <= pass_next;
      fail_reg      <= fail_next;
      code_reg      <= code_next;
      pend_pass_reg <= pend_pass_next;
      pend_fail_reg <= pend_fail_next;
      pend_code_reg <= pend_code_next;
    end
  end

  assign busy_o      = busy_reg;
  assign pass_o      = pass_reg;
  assign fail_o      = fail_reg;
  assign fail_code_o = code_reg;

  repchk_sat_cnt #(.W(STAT_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pass_reg),
    .cnt_o (pass_cnt_o)
  );

  repchk_sat_cnt #(.W(STAT_W)) u_fail_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (fail_reg),
    .cnt_o (fail_cnt_o)
  );

endmodule
